// File: rtl/emif_amm_pkg.sv
// Shared constants and types for the EMIF Avalon-MM channel multiplexer.
// BURST_W of any instance must not exceed BEATS_W.
package emif_amm_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_ADDR_W    = 28;
    localparam int DEF_DATA_W    = 576;
    localparam int DEF_BURST_W   = 7;
    localparam int DEF_RSP_DEPTH = 32;

    localparam int ID_W    = 3;
    localparam int BEATS_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_WBURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [BEATS_W-1:0] beats;
    } rsp_entry_t;

    localparam int ENTRY_W = $bits(rsp_entry_t);

    // A burstcount of zero moves one beat.
    function automatic logic [BEATS_W-1:0] eff_beats(input logic [BEATS_W-1:0] bc);
        return (bc == '0) ? BEATS_W'(1) : bc;
    endfunction

endpackage

// File: rtl/emif_amm_rsp_fifo.sv
// Read-tracker FIFO: one entry per accepted read burst, popped on its last beat.
// A push is accepted while full as long as a pop happens in the same cycle.
module emif_amm_rsp_fifo
    import emif_amm_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != (PTR_W+1)'(DEPTH)) | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/emif_amm_mux.sv
// Round-robin multiplexer of NUM_CH Avalon-MM masters onto one EMIF port,
// with write-burst locking and zero-latency read-response routing.
//   state     | meaning
//   ST_IDLE   | arbitrate each cycle among requesting channels from rr_ptr
//   ST_WBURST | grant locked to lock_id until the last write beat is accepted
module emif_amm_mux
    import emif_amm_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
)(
    input  logic                        emif_usr_clk,
    input  logic                        emif_usr_reset,
    input  logic [NUM_CH-1:0]           ch_read,
    input  logic [NUM_CH-1:0]           ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_address,
    input  logic [NUM_CH*DATA_W-1:0]    ch_writedata,
    input  logic [NUM_CH*BURST_W-1:0]   ch_burstcount,
    output logic [NUM_CH-1:0]           ch_ready,
    output logic [DATA_W-1:0]           ch_readdata,
    output logic [NUM_CH-1:0]           ch_readdatavalid,
    input  logic                        amm_ready,
    output logic                        amm_read,
    output logic                        amm_write,
    output logic [ADDR_W-1:0]           amm_address,
    output logic [DATA_W-1:0]           amm_writedata,
    output logic [BURST_W-1:0]          amm_burstcount,
    input  logic [DATA_W-1:0]           amm_readdata,
    input  logic                        amm_readdatavalid,
    output logic                        rsp_err,
    output logic [$clog2(RSP_DEPTH):0]  rd_outstanding
);

    localparam int CH_W = $clog2(NUM_CH);

    arb_state_t         state_q, state_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]    lock_id_q, lock_id_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEATS_W-1:0] hd_rem_q, hd_rem_d;
    logic               hd_act_q, hd_act_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_CH-1:0]  req;
    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_id;
    logic [CH_W-1:0]    gnt_nxt;
    logic               rd_ok, rd_acc, wr_acc;
    logic [BURST_W-1:0] wr_beats;
    logic [BEATS_W-1:0] hd_left;
    logic               rsp_beat, fifo_pop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    rsp_entry_t         head_e, push_e;

    assign head_e = rsp_entry_t'(fifo_head);

    // Response side: beats drain the head entry; the last beat pops it.
    always_comb begin
        hd_left  = hd_act_q ? hd_rem_q : head_e.beats;
        rsp_beat = amm_readdatavalid & ~fifo_empty;
        fifo_pop = rsp_beat & (hd_left == BEATS_W'(1));
        hd_act_d = hd_act_q;
        hd_rem_d = hd_rem_q;
        if (rsp_beat) begin
            hd_act_d = ~fifo_pop;
            hd_rem_d = hd_left - BEATS_W'(1);
        end
        rsp_err_d = rsp_err_q | (amm_readdatavalid & fifo_empty);
        ch_readdatavalid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_readdatavalid[i] = rsp_beat & (head_e.id == ID_W'(i));
        end
    end

    // Grant: the downward scan leaves the lowest offset from rr_ptr as winner.
    always_comb begin
        rd_ok = ~fifo_full | fifo_pop;
        req   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = ch_write[i] | (ch_read[i] & rd_ok);
        end
        if (emif_usr_reset) begin
            req = '0;
        end
        gnt_vld = 1'b0;
        gnt_id  = rr_ptr_q;
        if (state_q == ST_WBURST) begin
            gnt_vld = ~emif_usr_reset;
            gnt_id  = lock_id_q;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (req[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
                end
            end
        end
        gnt_nxt = (int'(gnt_id) == NUM_CH - 1) ? '0 : gnt_id + CH_W'(1);
    end

    always_comb begin
        amm_address    = ch_address[gnt_id*ADDR_W +: ADDR_W];
        amm_writedata  = ch_writedata[gnt_id*DATA_W +: DATA_W];
        amm_burstcount = ch_burstcount[gnt_id*BURST_W +: BURST_W];
        amm_write      = gnt_vld & ch_write[gnt_id];
        amm_read       = gnt_vld & (state_q == ST_IDLE) & ch_read[gnt_id]
                         & ~ch_write[gnt_id] & rd_ok;
        ch_ready = '0;
        if (gnt_vld) begin
            ch_ready[gnt_id] = amm_ready;
        end
        rd_acc   = amm_read & amm_ready;
        wr_acc   = amm_write & amm_ready;
        wr_beats = (amm_burstcount == '0) ? BURST_W'(1) : amm_burstcount;
        push_e.id    = ID_W'(gnt_id);
        push_e.beats = eff_beats(BEATS_W'(amm_burstcount));
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_acc) begin
                    rr_ptr_d = gnt_nxt;
                end else if (wr_acc) begin
                    if (wr_beats > BURST_W'(1)) begin
                        state_d    = ST_WBURST;
                        lock_id_d  = gnt_id;
                        beat_cnt_d = wr_beats - BURST_W'(1);
                    end else begin
                        rr_ptr_d = gnt_nxt;
                    end
                end
            end
            ST_WBURST: begin
                if (wr_acc) begin
                    if (beat_cnt_q == BURST_W'(1)) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = gnt_nxt;
                    end else begin
                        beat_cnt_d = beat_cnt_q - BURST_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge emif_usr_clk or posedge emif_usr_reset) begin
        if (emif_usr_reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
            hd_rem_q   <= '0;
            hd_act_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
            hd_rem_q   <= hd_rem_d;
            hd_act_q   <= hd_act_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    emif_amm_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (emif_usr_clk),
        .rst       (emif_usr_reset),
        .push      (rd_acc),
        .push_data (push_e),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rd_outstanding)
    );

    assign ch_readdata = amm_readdata;
    assign rsp_err     = rsp_err_q;

endmodule
